// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state, response record and parameter-legality helper for the data memory
package dmem_pkg;
    typedef enum logic {INIT, RUN} dmem_state_t;
    localparam int DMEM_MAX_W = 64;
    typedef struct packed {
        logic                  err;
        logic [DMEM_MAX_W-1:0] rdata;
    } dmem_rsp_t;
    function automatic bit dmem_params_ok(input int data_w, addr_w, depth, read_lat, rsp_depth);
        return (data_w > 0) && (data_w % 8 == 0) && (data_w <= DMEM_MAX_W) &&
               (depth >= 1) && (addr_w < 31) && (depth <= (1 << addr_w)) &&
               (read_lat >= 1) && (read_lat <= 4) && (rsp_depth >= read_lat);
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x DATA_W synchronous array with byte-lane writes and registered read
module dmem_array #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_W / 8; k++)
            if (i_we && i_be[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: handshaked data memory with init sweep, latency pipe, in-order response queue and credits
module data_memory_pipelined
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 1,
    parameter int RSP_DEPTH = 4,
    parameter int INIT_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(RSP_DEPTH + 1);
    localparam int PW   = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;

    if (!dmem_params_ok(DATA_W, ADDR_W, DEPTH, READ_LAT, RSP_DEPTH)) begin : g_bad_params
        $error("data_memory_pipelined: illegal parameter set");
    end

    dmem_state_t       r_state, w_next;
    logic [ADDR_W-1:0] r_init_cnt;
    logic [CW-1:0]     r_outst, r_qc;
    logic [PW-1:0]     r_wr, r_rd;
    logic              r_s0_v, r_s0_err, r_s0_rd;
    logic              w_init, w_err, w_acc, w_hs, w_push, w_pop, w_q_empty, w_last_v;
    logic              w_arr_we;
    logic [BE_W-1:0]   w_arr_be;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata, w_arr_rdata;
    dmem_rsp_t         w_s0, w_last, w_out;
    dmem_rsp_t         r_q [RSP_DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_init    = r_state == INIT;
    assign init_done = !w_init;
    assign w_err     = {1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH);
    assign req_ready = !w_init && (r_outst < CW'(RSP_DEPTH));
    assign w_acc     = req_valid && req_ready;

    always_comb w_next = (w_init && r_init_cnt == ADDR_W'(DEPTH - 1)) ? RUN : r_state;

    always_ff @(posedge clk) begin
        r_state    <= rst ? INIT : w_next;
        r_init_cnt <= rst ? '0 : r_init_cnt + ADDR_W'(w_init);
        r_outst    <= rst ? '0 : (w_acc && !w_hs) ? r_outst + 1'b1 : (!w_acc && w_hs) ? r_outst - 1'b1 : r_outst;
    end

    // The single array port belongs to the init sweep until RUN; out-of-range requests never write.
    assign w_arr_we    = w_init || (w_acc && req_we && !w_err);
    assign w_arr_be    = w_init ? '1 : req_be;
    assign w_arr_addr  = w_init ? r_init_cnt : req_addr;
    assign w_arr_wdata = w_init ? ((INIT_MODE != 0) ? '0 : DATA_W'(r_init_cnt)) : req_wdata;

    dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
        .clk    (clk),
        .i_we   (w_arr_we),
        .i_be   (w_arr_be),
        .i_addr (w_arr_addr),
        .i_wdata(w_arr_wdata),
        .o_rdata(w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        r_s0_v   <= !rst && w_acc;
        r_s0_err <= !rst && w_acc && w_err;
        r_s0_rd  <= !rst && w_acc && !req_we && !w_err;
    end

    assign w_s0 = '{err: r_s0_err, rdata: r_s0_rd ? DMEM_MAX_W'(w_arr_rdata) : '0};

    if (READ_LAT == 1) begin : g_lat1
        assign w_last   = w_s0;
        assign w_last_v = r_s0_v;
    end else begin : g_pipe
        logic [READ_LAT-2:0] r_pv;
        dmem_rsp_t           r_pd [READ_LAT-1];
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pv <= '0;
                for (int k = 0; k < READ_LAT - 1; k++) r_pd[k] <= '0;
            end else begin
                r_pv[0] <= r_s0_v;
                r_pd[0] <= w_s0;
                for (int k = 1; k < READ_LAT - 1; k++) begin
                    r_pv[k] <= r_pv[k-1];
                    r_pd[k] <= r_pd[k-1];
                end
            end
        end
        assign w_last   = r_pd[READ_LAT-2];
        assign w_last_v = r_pv[READ_LAT-2];
    end

    // An empty queue is bypassed so the pipe tail is visible immediately; credits keep it from overflowing.
    assign w_q_empty = r_qc == '0;
    assign rsp_valid = !w_q_empty || w_last_v;
    assign w_out     = w_q_empty ? w_last : r_q[r_rd];
    assign rsp_rdata = DATA_W'(w_out.rdata);
    assign rsp_err   = w_out.err;
    assign w_hs      = rsp_valid && rsp_ready;
    assign w_pop     = !w_q_empty && rsp_ready;
    assign w_push    = w_last_v && !(w_q_empty && rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
            r_qc <= '0;
        end else begin
            if (w_push) begin
                r_q[r_wr] <= w_last;
                r_wr      <= ptr_inc(r_wr);
            end
            if (w_pop) r_rd <= ptr_inc(r_rd);
            r_qc <= (w_push && !w_pop) ? r_qc + 1'b1 : (w_pop && !w_push) ? r_qc - 1'b1 : r_qc;
        end
    end
endmodule

// File: tb/tb_data_memory_pipelined.sv
// tb_data_memory_pipelined: scoreboard bench for a default instance (a) and a READ_LAT=3, DEPTH=1000 instance (b)
module tb_data_memory_pipelined;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err, a_init_done;
    logic [9:0]  a_req_addr;
    logic [23:0] a_req_wdata, a_rsp_rdata;
    logic [2:0]  a_req_be;
    logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_init_done;
    logic [9:0]  b_req_addr;
    logic [23:0] b_req_wdata, b_rsp_rdata;
    logic [2:0]  b_req_be;

    data_memory_pipelined u_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be), .rsp_valid(a_rsp_valid),
        .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .init_done(a_init_done)
    );

    data_memory_pipelined #(.READ_LAT(3), .RSP_DEPTH(4), .DEPTH(1000)) u_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .init_done(b_init_done)
    );

    typedef struct packed {
        logic [23:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   w, sum, bad, bad2, n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!a_rst && a_rsp_valid && a_rsp_ready) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_extra: got response rdata 0x%0h err %0b, required none", a_rsp_rdata, a_rsp_err);
            end else begin
                ea = exp_a.pop_front();
                chk("a_rdata", 32'(a_rsp_rdata), 32'(ea.rdata));
                chk("a_err", 32'(a_rsp_err), 32'(ea.err));
            end
        end
        if (!b_rst && b_rsp_valid && b_rsp_ready) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_extra: got response rdata 0x%0h err %0b, required none", b_rsp_rdata, b_rsp_err);
            end else begin
                eb = exp_b.pop_front();
                chk("b_rdata", 32'(b_rsp_rdata), 32'(eb.rdata));
                chk("b_err", 32'(b_rsp_err), 32'(eb.err));
            end
        end
    end

    task automatic issue(input bit sel, input bit we, input int addr, input logic [23:0] wd,
                         input logic [2:0] be, input logic [23:0] er, input bit ee, output int waited);
        int t = 0;
        if (sel) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr[9:0]; b_req_wdata = wd; b_req_be = be;
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr[9:0]; a_req_wdata = wd; a_req_be = be;
        end
        @(negedge clk);
        while (!(sel ? b_req_ready : a_req_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept of addr %0d in %0d cycles, required accept", addr, t);
            if (sel) b_req_valid = 1'b0;
            else a_req_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (sel) exp_b.push_back('{er, ee});
            else exp_a.push_back('{er, ee});
            #1;
        end
    endtask

    task automatic drain(input bit sel);
        int t = 0;
        while ((sel ? exp_b.size() : exp_a.size()) != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sel ? exp_b.size() : exp_a.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_be} = '0;
        {b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_be} = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(a_req_ready), 0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(a_rsp_rdata), 0);
        chk("rst_rsp_err", 32'(a_rsp_err), 0);
        chk("rst_init_done", 32'(a_init_done), 0);
        chk("rst_b_rsp_valid", 32'(b_rsp_valid), 0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        bad = 0; sum = 0; n = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (!a_init_done) begin
                sum++;
                if (a_req_ready) bad++;
            end
            if (!b_init_done) begin
                n++;
                if (b_req_ready) bad++;
            end
        end
        chk("a_init_cycles", 32'(sum), 1024);
        chk("b_init_cycles", 32'(n), 1000);
        chk("init_ready_low", 32'(bad), 0);
        @(posedge clk);
        #1;
        // basic read and one-cycle latency
        issue(0, 0, 5, 24'h0, 3'b000, 24'd5, 0, w);
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_latency", 32'(a_rsp_valid), 1);
        drain(0);
        // write then back-to-back read of the same word
        issue(0, 1, 10, 24'hABCDEF, 3'b111, 24'h0, 0, w);
        issue(0, 0, 10, 24'h0, 3'b000, 24'hABCDEF, 0, w);
        a_req_valid = 1'b0;
        drain(0);
        // byte lanes, empty byte-enable, top address
        issue(0, 1, 20, 24'h123456, 3'b010, 24'h0, 0, w);
        issue(0, 0, 20, 24'h0, 3'b000, 24'h003414, 0, w);
        issue(0, 1, 30, 24'hFFFFFF, 3'b000, 24'h0, 0, w);
        issue(0, 0, 30, 24'h0, 3'b000, 24'h00001E, 0, w);
        issue(0, 0, 1023, 24'h0, 3'b000, 24'h0003FF, 0, w);
        a_req_valid = 1'b0;
        drain(0);
        // backpressure on the READ_LAT=3 instance
        b_rsp_ready = 1'b0;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, i, 24'h0, 3'b000, 24'(i), 0, w);
            sum += w;
        end
        chk("t4_accept_waits", 32'(sum), 0);
        b_req_addr = 10'd4;
        bad = 0; bad2 = 0;
        repeat (4) begin
            @(negedge clk);
            if (b_req_ready) bad++;
            if (!b_rsp_valid || b_rsp_rdata !== 24'h0) bad2++;
        end
        chk("t4_full_ready", 32'(bad), 0);
        chk("t4_hold_head", 32'(bad2), 0);
        b_rsp_ready = 1'b1;
        for (int i = 4; i < 10; i++) issue(1, 0, i, 24'h0, 3'b000, 24'(i), 0, w);
        b_req_valid = 1'b0;
        drain(1);
        sum = 0;
        for (int i = 0; i < 12; i++) begin
            issue(1, 0, 100 + i, 24'h0, 3'b000, 24'(100 + i), 0, w);
            sum += w;
        end
        b_req_valid = 1'b0;
        chk("t4_throughput", 32'(sum), 0);
        drain(1);
        issue(1, 0, 7, 24'h0, 3'b000, 24'd7, 0, w);
        b_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_rsp_valid && n < 10);
        chk("t4_latency", 32'(n), 3);
        drain(1);
        // out-of-range addresses on the DEPTH=1000 instance
        issue(1, 1, 1000, 24'h111111, 3'b111, 24'h0, 1, w);
        issue(1, 0, 1000, 24'h0, 3'b000, 24'h0, 1, w);
        issue(1, 0, 999, 24'h0, 3'b000, 24'd999, 0, w);
        b_req_valid = 1'b0;
        drain(1);
        // reset with responses pending
        a_rsp_ready = 1'b0;
        for (int i = 1; i < 4; i++) issue(0, 0, i, 24'h0, 3'b000, 24'(i), 0, w);
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("t6_pending_valid", 32'(a_rsp_valid), 1);
        @(negedge clk);
        chk("t6_hold_rdata", 32'(a_rsp_rdata), 1);
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        exp_a.delete();
        a_rsp_ready = 1'b1;
        @(negedge clk);
        chk("t6_flush_valid", 32'(a_rsp_valid), 0);
        n = 0;
        while (!a_init_done && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_init_done", 32'(a_init_done), 1);
        @(posedge clk);
        #1;
        issue(0, 0, 10, 24'h0, 3'b000, 24'd10, 0, w);
        a_req_valid = 1'b0;
        drain(0);
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
